multi_port_fifo: RTL and testbench
==================================

// Module: multi_port_fifo
// PURPOSE
//  Superscalar circular FIFO: up to WR_PORTS entries enqueued and up to RD_PORTS dequeued per cycle.
//  Adds flush, occupancy/free counts and a parametric data type.
//  Used as the decode->dispatch instruction queue and for other multi-wide buffers in the OoO core.
//  Enqueue is all-or-nothing per cycle; dequeue is partial (takes what is available).
// PARAMETERS
//  WIDTH     32                     payload width when DTYPE is left at its default
//  DEPTH     8                      entries; power of 2, >= max(WR_PORTS, RD_PORTS), >= 2
//  WR_PORTS  2                      max enqueues per cycle, >= 1
//  RD_PORTS  2                      max dequeues per cycle, >= 1
//  DTYPE     logic[WIDTH-1:0]       entry type
//  (local) PTR_WIDTH = $clog2(DEPTH); CNT_WIDTH = $clog2(DEPTH+1)
//  (local) WC_WIDTH  = $clog2(WR_PORTS+1); RC_WIDTH = $clog2(RD_PORTS+1)
// PORTS
//  clk     in   1                      clock; all state updates on posedge
//  rst     in   1                      synchronous, active-high reset
//  flush   in   1                      discard all contents this cycle
//  wcount  in   WC_WIDTH               number of entries to enqueue (lanes 0..wcount-1)
//  wdata   in   DTYPE[WR_PORTS]        lane i holds the i-th entry in program order
//  wready  out  1                      wcount <= free; enqueue accepted iff wready
//  rcount  in   RC_WIDTH               number of entries the consumer takes this cycle
//  rdata   out  DTYPE[RD_PORTS]        rdata[i] = entry at (head + i)
//  rvalid  out  RD_PORTS               rvalid[i] = (i < count)
//  count   out  CNT_WIDTH              current occupancy, 0..DEPTH
//  free    out  CNT_WIDTH              DEPTH - count
//  full    out  1                      count == DEPTH
//  empty   out  1                      count == 0
// BEHAVIOUR
//  - Pointers wptr and rptr are PTR_WIDTH+1 bits with a wrap bit; count = wptr - rptr (mod 2^(PTR_WIDTH+1)).
//    Slot index = ptr[PTR_WIDTH-1:0]; increments wrap naturally modulo DEPTH.
//  - Reset (rst=1 at posedge): wptr = rptr = 0.
//    Next cycle: count=0, free=DEPTH, empty=1, full=0, rvalid=0, wready=1 for any wcount.
//    Storage array is not reset; rdata is don't-care while rvalid=0.
//  - All outputs are combinational from registered state, plus wcount for wready. Zero-cycle read latency:
//    rdata/rvalid reflect state at the start of the cycle.
//  - Enqueue: if flush=0 and wcount != 0 and wcount <= free (start-of-cycle value):
//    mem[wptr+i] <= wdata[i] for i < wcount, and wptr += wcount.
//    Otherwise there is no write and wptr holds; a partial enqueue never happens.
//  - Dequeue: n = min(rcount, count); rptr += n (no flush).
//    rcount > count is legal and saturates to count; it is not an error.
//  - Simultaneous enqueue and dequeue: space freed by this cycle's dequeue is NOT visible to this cycle's
//    wready (no bypass). Both pointer updates apply in the same edge.
//  - An enqueue into an empty FIFO is not forwarded to rdata in the same cycle; it is readable the next cycle.
//  - flush=1 (rst=0): rptr <= wptr (queue emptied, wptr unchanged). The same-cycle enqueue and dequeue are
//    both ignored. wready is still driven normally, but the write is dropped.
//  - rst has priority over flush, which has priority over enqueue/dequeue. Reset mid-operation discards
//    all contents.
//  - Wrap-around: multi-lane writes and reads that straddle slot DEPTH-1 -> 0 are handled per lane modulo DEPTH.
//  - Assertions (sim only): DEPTH is a power of 2; count <= DEPTH always;
//    wcount <= WR_PORTS; rcount <= RD_PORTS.
// TESTING (DEPTH=8, WR_PORTS=2, RD_PORTS=2, WIDTH=32)
//  1. Reset, then wcount=2 with {A,B} for 4 cycles -> count=8, full=1.
//     A 5th wcount=1 gives wready=0, state unchanged.
//  2. Fill to 7, then wcount=2 -> wready=0, nothing written.
//     Same state with wcount=1 -> accepted, count=8.
//  3. Steady state: count=4, wcount=2 and rcount=2 every cycle for 10 cycles -> count stays 4,
//     data order preserved across wrap.
//  4. count=1, rcount=2 -> rvalid=2'b01, one entry removed, empty=1 next cycle.
//  5. count=6, wcount=2 + rcount=2 -> wready=1, count=6.
//     count=7, wcount=2 + rcount=2 -> wready=0 (no bypass), count=5.
//  6. count=5, flush=1 with wcount=2 and rcount=1 -> count=0, empty=1.
//     Next enqueue of C is read back as rdata[0]=C.
//     Also: rst asserted mid-stream -> count=0, rvalid=0.

Source files
------------

// File: rtl/multi_port_fifo.sv
// multi_port_fifo: superscalar circular FIFO.
// Up to WR_PORTS entries enter per cycle (all-or-nothing) and up to RD_PORTS
// leave per cycle (saturating at the current occupancy). Pointers carry one
// extra wrap bit so that full and empty stay distinguishable without a counter.
// Outputs are combinational from the registered pointers, plus wcount for wready.

// Simulation-only property checker for the FIFO.
module multi_port_fifo_chk #(
   parameter int DEPTH     = 8,
   parameter int WR_PORTS  = 2,
   parameter int RD_PORTS  = 2,
   parameter int CNT_WIDTH = 4,
   parameter int WC_WIDTH  = 2,
   parameter int RC_WIDTH  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CNT_WIDTH-1:0] count,
   input  logic [WC_WIDTH-1:0]  wcount,
   input  logic [RC_WIDTH-1:0]  rcount
);
   a_depth_pow2: assert property (@(posedge clk) ((DEPTH & (DEPTH - 32'sd1)) == 32'sd0))
      else $error("multi_port_fifo: DEPTH is not a power of 2");
   a_count_max: assert property (@(posedge clk) disable iff (rst) (int'(count) <= DEPTH))
      else $error("multi_port_fifo: occupancy exceeds DEPTH");
   a_wcount_max: assert property (@(posedge clk) disable iff (rst) (int'(wcount) <= WR_PORTS))
      else $error("multi_port_fifo: wcount exceeds WR_PORTS");
   a_rcount_max: assert property (@(posedge clk) disable iff (rst) (int'(rcount) <= RD_PORTS))
      else $error("multi_port_fifo: rcount exceeds RD_PORTS");
endmodule

module multi_port_fifo #(
   parameter int  WIDTH     = 32,
   parameter int  DEPTH     = 8,
   parameter int  WR_PORTS  = 2,
   parameter int  RD_PORTS  = 2,
   parameter type DTYPE     = logic [WIDTH-1:0],
   localparam int PTR_WIDTH = $clog2(DEPTH),
   localparam int CNT_WIDTH = $clog2(DEPTH + 1),
   localparam int WC_WIDTH  = $clog2(WR_PORTS + 1),
   localparam int RC_WIDTH  = $clog2(RD_PORTS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic [WC_WIDTH-1:0]  wcount,
   input  DTYPE                 wdata [WR_PORTS],
   output logic                 wready,
   input  logic [RC_WIDTH-1:0]  rcount,
   output DTYPE                 rdata [RD_PORTS],
   output logic [RD_PORTS-1:0]  rvalid,
   output logic [CNT_WIDTH-1:0] count,
   output logic [CNT_WIDTH-1:0] free,
   output logic                 full,
   output logic                 empty
);
   localparam int PW = PTR_WIDTH + 1;

   logic [PW-1:0]        wptr_r;
   logic [PW-1:0]        rptr_r;
   DTYPE                 mem_r [DEPTH];

   logic [PW-1:0]        occ_s;
   logic [CNT_WIDTH-1:0] count_s;
   logic [CNT_WIDTH-1:0] free_s;
   logic [CNT_WIDTH-1:0] rc_ext_s;
   logic [CNT_WIDTH-1:0] deq_n_s;
   logic                 wready_s;
   logic                 enq_s;

   // Occupancy and per-cycle enqueue/dequeue decisions from start-of-cycle state.
   // Space freed by this cycle's dequeue is deliberately not offered to wready.
   always_comb begin
      occ_s    = wptr_r - rptr_r;
      count_s  = CNT_WIDTH'(occ_s);
      free_s   = CNT_WIDTH'(DEPTH) - count_s;
      rc_ext_s = CNT_WIDTH'(rcount);
      wready_s = (CNT_WIDTH'(wcount) <= free_s);
      if (rc_ext_s < count_s) begin
         deq_n_s = rc_ext_s;
      end else begin
         deq_n_s = count_s;
      end
      if (!flush && (wcount != '0) && wready_s) begin
         enq_s = 1'b1;
      end else begin
         enq_s = 1'b0;
      end
   end

   // Read lanes: lane i shows the entry at head + i, wrapping modulo DEPTH.
   always_comb begin
      logic [PTR_WIDTH-1:0] rd_idx;
      rd_idx = '0;
      for (int i = 0; i < RD_PORTS; i++) begin
         rd_idx    = rptr_r[PTR_WIDTH-1:0] + PTR_WIDTH'(i);
         rdata[i]  = mem_r[rd_idx];
         rvalid[i] = (CNT_WIDTH'(i) < count_s);
      end
   end

   assign wready = wready_s;
   assign count  = count_s;
   assign free   = free_s;
   assign full   = (count_s == CNT_WIDTH'(DEPTH));
   assign empty  = (count_s == '0);

   // Pointer update: reset beats flush, flush beats enqueue/dequeue.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_r <= '0;
         rptr_r <= '0;
      end else if (flush) begin
         rptr_r <= wptr_r;
      end else begin
         if (enq_s) begin
            wptr_r <= wptr_r + PW'(wcount);
         end
         rptr_r <= rptr_r + PW'(deq_n_s);
      end
   end

   // Storage write: lanes 0..wcount-1 land in consecutive slots, wrapping per lane.
   // The array is intentionally not reset; rvalid qualifies its contents.
   always_ff @(posedge clk) begin
      logic [PTR_WIDTH-1:0] wr_idx;
      wr_idx = '0;
      for (int i = 0; i < WR_PORTS; i++) begin
         wr_idx = wptr_r[PTR_WIDTH-1:0] + PTR_WIDTH'(i);
         if (!rst && enq_s && (i < int'(wcount))) begin
            mem_r[wr_idx] <= wdata[i];
         end
      end
   end

   multi_port_fifo_chk #(
      .DEPTH     (DEPTH),
      .WR_PORTS  (WR_PORTS),
      .RD_PORTS  (RD_PORTS),
      .CNT_WIDTH (CNT_WIDTH),
      .WC_WIDTH  (WC_WIDTH),
      .RC_WIDTH  (RC_WIDTH)
   ) u_chk (
      .clk    (clk),
      .rst    (rst),
      .count  (count_s),
      .wcount (wcount),
      .rcount (rcount)
   );
endmodule

// File: tb/tb_multi_port_fifo.sv
// Testbench for multi_port_fifo (DEPTH=8, 2 write lanes, 2 read lanes, 32-bit).
// A queue-based reference model tracks expected contents; directed scenarios
// also check against fixed expected values.
module tb_multi_port_fifo;
   localparam int D = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [1:0]  wcount;
   logic [31:0] wdata [2];
   logic        wready;
   logic [1:0]  rcount;
   logic [31:0] rdata [2];
   logic [1:0]  rvalid;
   logic [3:0]  count;
   logic [3:0]  free;
   logic        full;
   logic        empty;

   int total = 0;
   int bad   = 0;
   logic [31:0] mq [$];

   always #5 clk = ~clk;

   multi_port_fifo #(.WIDTH(32), .DEPTH(8), .WR_PORTS(2), .RD_PORTS(2)) dut (
      .clk(clk), .rst(rst), .flush(flush), .wcount(wcount), .wdata(wdata),
      .wready(wready), .rcount(rcount), .rdata(rdata), .rvalid(rvalid),
      .count(count), .free(free), .full(full), .empty(empty)
   );

   // Apply inputs and let combinational outputs settle.
   task automatic drive(input logic r, input logic f, input int wc,
                        input logic [31:0] a, input logic [31:0] b, input int rc);
      rst = r; flush = f; wcount = 2'(wc); wdata[0] = a; wdata[1] = b; rcount = 2'(rc);
      #1;
   endtask

   // Clock one edge and advance the reference model by the FIFO rules.
   task automatic cycle();
      int sz, n;
      bit acc;
      @(posedge clk);
      sz = mq.size();
      if (rst || flush) begin
         mq.delete();
      end else begin
         acc = (wcount != 2'd0) && (int'(wcount) <= D - sz);
         n = (int'(rcount) < sz) ? int'(rcount) : sz;
         repeat (n) void'(mq.pop_front());
         if (acc) for (int i = 0; i < int'(wcount); i++) mq.push_back(wdata[i]);
      end
      #1;
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 0, 32'h0, 32'h0, 0);
      cycle();
   endtask

   task automatic test_reset();
      do_reset();
      drive(1'b0, 1'b0, 2, 32'h1, 32'h2, 0);
      total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
      total++; if (free !== 4'd8) begin bad++; $display("FAIL reset_free got=%0d want=8", free); end
      total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_flags got empty=%b full=%b want 1 0", empty, full); end
      total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL reset_rvalid got=%b want=00", rvalid); end
      total++; if (wready !== 1'b1) begin bad++; $display("FAIL reset_wready got=%b want=1", wready); end
   endtask

   task automatic test_fill_full();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, 2, 32'hA000 + 32'(k), 32'hB000 + 32'(k), 0);
         cycle();
      end
      drive(1'b0, 1'b0, 1, 32'hDEAD, 32'h0, 0);
      total++; if (count !== 4'd8 || full !== 1'b1) begin bad++; $display("FAIL full_state got count=%0d full=%b want 8 1", count, full); end
      total++; if (wready !== 1'b0) begin bad++; $display("FAIL full_wready got=%b want=0", wready); end
      cycle();
      drive(1'b0, 1'b0, 0, 32'h0, 32'h0, 2);
      total++; if (count !== 4'd8) begin bad++; $display("FAIL full_hold got=%0d want=8", count); end
      total++; if (rdata[0] !== 32'hA000 || rdata[1] !== 32'hB000) begin bad++; $display("FAIL full_head got=%h %h want=a000 b000", rdata[0], rdata[1]); end
      // Drain fully, checking order against the model.
      for (int k = 0; k < 4; k++) begin
         total++; if (rdata[0] !== mq[0] || rdata[1] !== mq[1]) begin bad++; $display("FAIL full_drain got=%h %h want=%h %h", rdata[0], rdata[1], mq[0], mq[1]); end
         cycle();
      end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_drained got empty=%b want=1", empty); end
   endtask

   task automatic test_almost_full();
      do_reset();
      for (int k = 0; k < 3; k++) begin drive(1'b0, 1'b0, 2, $urandom, $urandom, 0); cycle(); end
      drive(1'b0, 1'b0, 1, $urandom, 32'h0, 0); cycle();
      drive(1'b0, 1'b0, 2, 32'h1111, 32'h2222, 0);
      total++; if (count !== 4'd7 || wready !== 1'b0) begin bad++; $display("FAIL af_reject got count=%0d wready=%b want 7 0", count, wready); end
      cycle();
      drive(1'b0, 1'b0, 1, 32'h3333, 32'h0, 0);
      total++; if (count !== 4'd7 || wready !== 1'b1) begin bad++; $display("FAIL af_accept got count=%0d wready=%b want 7 1", count, wready); end
      cycle();
      drive(1'b0, 1'b0, 0, 32'h0, 32'h0, 0);
      total++; if (count !== 4'd8 || full !== 1'b1) begin bad++; $display("FAIL af_full got count=%0d full=%b want 8 1", count, full); end
   endtask

   task automatic test_steady_wrap();
      do_reset();
      for (int k = 0; k < 2; k++) begin drive(1'b0, 1'b0, 2, $urandom, $urandom, 0); cycle(); end
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 1'b0, 2, $urandom, $urandom, 2);
         total++; if (rdata[0] !== mq[0] || rdata[1] !== mq[1] || wready !== 1'b1) begin bad++; $display("FAIL steady_data got=%h %h rdy=%b want=%h %h 1", rdata[0], rdata[1], wready, mq[0], mq[1]); end
         cycle();
         total++; if (count !== 4'd4) begin bad++; $display("FAIL steady_count got=%0d want=4", count); end
      end
   endtask

   task automatic test_underflow_read();
      do_reset();
      drive(1'b0, 1'b0, 1, 32'h5A5A, 32'h0, 0); cycle();
      drive(1'b0, 1'b0, 0, 32'h0, 32'h0, 2);
      total++; if (rvalid !== 2'b01 || rdata[0] !== 32'h5A5A) begin bad++; $display("FAIL under_rvalid got=%b %h want=01 5a5a", rvalid, rdata[0]); end
      cycle();
      drive(1'b0, 1'b0, 0, 32'h0, 32'h0, 0);
      total++; if (empty !== 1'b1 || count !== 4'd0) begin bad++; $display("FAIL under_empty got empty=%b count=%0d want 1 0", empty, count); end
   endtask

   task automatic test_no_bypass();
      do_reset();
      for (int k = 0; k < 3; k++) begin drive(1'b0, 1'b0, 2, $urandom, $urandom, 0); cycle(); end
      drive(1'b0, 1'b0, 2, $urandom, $urandom, 2);
      total++; if (wready !== 1'b1) begin bad++; $display("FAIL nb6_wready got=%b want=1", wready); end
      cycle();
      drive(1'b0, 1'b0, 1, $urandom, 32'h0, 0);
      total++; if (count !== 4'd6) begin bad++; $display("FAIL nb6_count got=%0d want=6", count); end
      cycle();
      drive(1'b0, 1'b0, 2, $urandom, $urandom, 2);
      total++; if (wready !== 1'b0) begin bad++; $display("FAIL nb7_wready got=%b want=0", wready); end
      cycle();
      drive(1'b0, 1'b0, 0, 32'h0, 32'h0, 0);
      total++; if (count !== 4'd5 || rdata[0] !== mq[0]) begin bad++; $display("FAIL nb7_after got count=%0d rd0=%h want 5 %h", count, rdata[0], mq[0]); end
   endtask

   task automatic test_flush();
      do_reset();
      for (int k = 0; k < 2; k++) begin drive(1'b0, 1'b0, 2, $urandom, $urandom, 0); cycle(); end
      drive(1'b0, 1'b0, 1, $urandom, 32'h0, 0); cycle();
      drive(1'b0, 1'b1, 2, 32'hEEEE, 32'hFFFF, 1);
      total++; if (count !== 4'd5 || wready !== 1'b1) begin bad++; $display("FAIL flush_pre got count=%0d wready=%b want 5 1", count, wready); end
      cycle();
      drive(1'b0, 1'b0, 1, 32'hC0C0C0C0, 32'h0, 0);
      total++; if (count !== 4'd0 || empty !== 1'b1) begin bad++; $display("FAIL flush_empty got count=%0d empty=%b want 0 1", count, empty); end
      cycle();
      drive(1'b0, 1'b0, 0, 32'h0, 32'h0, 0);
      total++; if (rdata[0] !== 32'hC0C0C0C0 || rvalid !== 2'b01) begin bad++; $display("FAIL flush_c got=%h rv=%b want=c0c0c0c0 01", rdata[0], rvalid); end
      // Reset in the middle of traffic, with a write also pending.
      drive(1'b0, 1'b0, 2, $urandom, $urandom, 0); cycle();
      drive(1'b1, 1'b0, 2, $urandom, $urandom, 1); cycle();
      drive(1'b0, 1'b0, 0, 32'h0, 32'h0, 0);
      total++; if (count !== 4'd0 || rvalid !== 2'b00) begin bad++; $display("FAIL midrst got count=%0d rvalid=%b want 0 00", count, rvalid); end
   endtask

   task automatic test_random();
      int sz;
      logic [1:0] erv;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 19) == 0),
               $urandom_range(0, 2), $urandom, $urandom, $urandom_range(0, 2));
         sz = mq.size();
         erv = {(sz > 1), (sz > 0)};
         total++; if (int'(count) != sz || int'(free) != D - sz || full !== (sz == D) || empty !== (sz == 0)) begin
            bad++; $display("FAIL rnd_status got count=%0d free=%0d full=%b empty=%b want count=%0d", count, free, full, empty, sz);
         end
         total++; if (wready !== (int'(wcount) <= D - sz) || rvalid !== erv) begin
            bad++; $display("FAIL rnd_ready got wready=%b rvalid=%b want rvalid=%b", wready, rvalid, erv);
         end
         total++; if ((sz > 0 && rdata[0] !== mq[0]) || (sz > 1 && rdata[1] !== mq[1])) begin
            bad++; $display("FAIL rnd_data got=%h %h size=%0d", rdata[0], rdata[1], sz);
         end
         cycle();
      end
   endtask

   initial begin
      test_reset();
      test_fill_full();
      test_almost_full();
      test_steady_wrap();
      test_underflow_read();
      test_no_bypass();
      test_flush();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
